// File: rtl/sample_serializer.sv
// Sample FIFO feeding an MSB-first serializer: decimated words are queued and
// shifted out one bit per clock, with gapless back-to-back words when downstream is ready.
module sample_serializer #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   new_data,
  input  logic                   sout_ready,
  input  logic                   clr_ovf,
  output logic                   sout,
  output logic                   sout_frame,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   empty,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH-1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] head;
  logic             full;
  logic             boundary;
  logic             pop;
  logic             push;
  logic             drop;
  logic [AW:0]      count_nxt;

  // Pops happen only at word boundaries; empty is registered, so a word pushed
  // into an empty FIFO cannot be popped on the same edge.
  always_comb begin
    head      = mem[rd_ptr];
    full      = (fifo_count == FULL_CNT);
    boundary  = (state == IDLE) || (bit_cnt == '0);
    pop       = boundary && !empty && sout_ready;
    push      = new_data && (!full || pop);
    drop      = new_data && full && !pop;
    count_nxt = fifo_count;
    if (push && !pop)
      count_nxt = fifo_count + 1'b1;
    else if (pop && !push)
      count_nxt = fifo_count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_count <= '0;
      empty      <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      state      <= IDLE;
      bit_cnt    <= '0;
      sout       <= 1'b0;
      sout_frame <= 1'b0;
    end else begin
      fifo_count <= count_nxt;
      empty      <= (count_nxt == '0);
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      // A drop on the same edge as a clear keeps the flag set.
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;

      if (pop) begin
        state      <= SHIFT;
        bit_cnt    <= LAST_BIT;
        sout       <= head[WIDTH-1];
        sout_frame <= 1'b1;
      end else if (state == SHIFT && bit_cnt != '0) begin
        bit_cnt <= bit_cnt - 1'b1;
        sout    <= shreg[WIDTH-2];
      end else begin
        state      <= IDLE;
        bit_cnt    <= '0;
        sout       <= 1'b0;
        sout_frame <= 1'b0;
      end
    end
  end

  // Storage and shift register carry no reset; control alone decides validity.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= data_in;
    if (pop)
      shreg <= head;
    else if (state == SHIFT)
      shreg <= shreg << 1;
  end

endmodule

// File: tb/tb_sample_serializer.sv
// Scoreboard bench for sample_serializer: accepted samples are queued at push
// time and compared against words reassembled from the serial stream.
module tb_sample_serializer;
  localparam int WIDTH = 12;
  localparam int DEPTH = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [WIDTH-1:0]       data_in = '0;
  logic                   new_data = 1'b0;
  logic                   sout_ready = 1'b0;
  logic                   clr_ovf = 1'b0;
  logic                   sout;
  logic                   sout_frame;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   empty;
  logic                   overflow;

  sample_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .new_data(new_data),
    .sout_ready(sout_ready), .clr_ovf(clr_ovf), .sout(sout),
    .sout_frame(sout_frame), .fifo_count(fifo_count), .empty(empty),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int               n_vec = 0;
  int               n_err = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] mon_word = '0;
  logic [WIDTH-1:0] exp_word;
  int               mon_bits = 0;
  int               run = 0;
  int               last_run = 0;
  int               words_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reassemble serial words and measure contiguous frame runs.
  always @(negedge clk) begin
    if (rst) begin
      mon_bits = 0;
      run      = 0;
    end else if (sout_frame) begin
      mon_word = {mon_word[WIDTH-2:0], sout};
      mon_bits++;
      run++;
      if (mon_bits == WIDTH) begin
        mon_bits = 0;
        words_seen++;
        chk("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_word = exp_q.pop_front();
          chk("word_data", mon_word, exp_word);
        end
      end
    end else if (run != 0) begin
      last_run = run;
      run      = 0;
    end
  end

  task automatic push(input logic [WIDTH-1:0] d, input bit accept);
    data_in  = d;
    new_data = 1'b1;
    if (accept)
      exp_q.push_back(d);
    @(posedge clk);
    #1;
    new_data = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (!sout_frame && empty)
        done = 1'b1;
    end
    chk("idle_reached", done, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int ws;
    bit fell;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sout", sout, 0);
    chk("rst_frame", sout_frame, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    // Single sample and first-word latency
    sout_ready = 1'b1;
    push(12'hA5C, 1'b1);
    @(negedge clk);
    chk("lat_frame_low", sout_frame, 0);
    chk("lat_count", fifo_count, 1);
    @(negedge clk);
    chk("lat_frame_high", sout_frame, 1);
    chk("lat_msb", sout, 1);
    wait_idle(40);
    chk("single_run", last_run, 12);
    chk("single_empty", empty, 1);

    // Back-to-back words
    push(12'hFFF, 1'b1);
    push(12'h001, 1'b1);
    wait_idle(60);
    chk("b2b_run", last_run, 24);

    // Overflow: ninth sample dropped
    sout_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      push(12'h100 + WIDTH'(i), i < 8);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_flag", overflow, 1);
    @(posedge clk);
    #1;
    chk("ovf_sticky", overflow, 1);
    sout_ready = 1'b1;
    wait_idle(200);
    chk("ovf_after_drain", overflow, 1);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Full FIFO with push on the same edge as a boundary pop
    sout_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      push(12'h200 + WIDTH'(i), 1'b1);
    chk("full_count", fifo_count, 8);
    sout_ready = 1'b1;
    @(posedge clk);
    #1;
    push(12'h2AA, 1'b1);
    chk("refill_count", fifo_count, 8);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_boundary_frame", sout_frame, 1);
    push(12'h2BB, 1'b1);
    chk("pp_count", fifo_count, 8);
    chk("pp_ovf", overflow, 0);
    wait_idle(300);
    chk("pp_run", last_run, 120);

    // Ready dropped mid-word
    sout_ready = 1'b0;
    push(12'hB01, 1'b1);
    push(12'h3C7, 1'b1);
    sout_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) @(posedge clk);
    #1;
    sout_ready = 1'b0;
    fell = 1'b0;
    for (int i = 0; i < 20 && !fell; i++) begin
      @(negedge clk);
      if (!sout_frame)
        fell = 1'b1;
    end
    chk("hold_word_end", fell, 1);
    repeat (6) @(negedge clk);
    chk("hold_idle", sout_frame, 0);
    chk("hold_count", fifo_count, 1);
    @(posedge clk);
    #1;
    chk("hold_run", last_run, 12);
    sout_ready = 1'b1;
    wait_idle(60);

    // Reset mid-word with samples queued
    sout_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(12'h300 + WIDTH'(i), 1'b1);
    sout_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_frame", sout_frame, 0);
    chk("mid_rst_sout", sout, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_empty", empty, 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ws = words_seen;
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (sout_frame)
        hi++;
    end
    chk("post_rst_silent", hi, 0);
    chk("post_rst_words", words_seen, ws);
    @(posedge clk);
    #1;
    push(12'h5A3, 1'b1);
    wait_idle(40);
    chk("post_rst_run", last_run, 12);

    chk("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
